// File: rtl/fetch_decode_skid_reg.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer, valid/ready handshake and flush.
// Build option FETCH_REG_FLUSH_NOP_EN: flush also overwrites held instruction fields with NOP_INSTR.
module fetch_decode_skid_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] read_data_f,
  input  logic [DATA_WIDTH-1:0] PC_f,
  input  logic [DATA_WIDTH-1:0] PCPlus4_f,
  input  logic                  valid_f,
  output logic                  ready_f,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] read_data_d,
  output logic [DATA_WIDTH-1:0] PC_d,
  output logic [DATA_WIDTH-1:0] PCPlus4_d,
  output logic                  valid_d,
  input  logic                  ready_d
);

  // The state encodes both valid bits: main is valid in ONE/FULL, skid only in FULL.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] instr_reg, instr_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] pc4_reg, pc4_next;
  logic [DATA_WIDTH-1:0] skid_instr_reg, skid_instr_next;
  logic [DATA_WIDTH-1:0] skid_pc_reg, skid_pc_next;
  logic [DATA_WIDTH-1:0] skid_pc4_reg, skid_pc4_next;
  logic                  in_xfer;
  logic                  out_xfer;

  // Both handshake outputs come straight from the state register, so no ready_d -> ready_f path.
  assign valid_d     = (state_reg != EMPTY);
  assign ready_f     = (state_reg != FULL);
  assign read_data_d = instr_reg;
  assign PC_d        = pc_reg;
  assign PCPlus4_d   = pc4_reg;

  assign in_xfer  = valid_f & ready_f & ~flush;
  assign out_xfer = valid_d & ready_d;

  always_comb begin
    state_next      = state_reg;
    instr_next      = instr_reg;
    pc_next         = pc_reg;
    pc4_next        = pc4_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    skid_pc4_next   = skid_pc4_reg;
    if (flush) begin
      state_next = EMPTY;
`ifdef FETCH_REG_FLUSH_NOP_EN
      instr_next      = NOP_INSTR;
      skid_instr_next = NOP_INSTR;
`endif
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next = ONE;
            instr_next = read_data_f;
            pc_next    = PC_f;
            pc4_next   = PCPlus4_f;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            instr_next = read_data_f;
            pc_next    = PC_f;
            pc4_next   = PCPlus4_f;
          end else if (in_xfer) begin
            // Decode stalled: park the new beat so ready_f can stay registered.
            state_next      = FULL;
            skid_instr_next = read_data_f;
            skid_pc_next    = PC_f;
            skid_pc4_next   = PCPlus4_f;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next = ONE;
            instr_next = skid_instr_reg;
            pc_next    = skid_pc_reg;
            pc4_next   = skid_pc4_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      instr_reg      <= NOP_INSTR;
      pc_reg         <= '0;
      pc4_reg        <= '0;
      skid_instr_reg <= NOP_INSTR;
      skid_pc_reg    <= '0;
      skid_pc4_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      instr_reg      <= instr_next;
      pc_reg         <= pc_next;
      pc4_reg        <= pc4_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      skid_pc4_reg   <= skid_pc4_next;
    end
  end

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
// Directed self-checking bench for fetch_decode_skid_reg: streaming, back-pressure, flush, async reset, bubbles.
module tb_fetch_decode_skid_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] read_data_f, PC_f, PCPlus4_f;
  logic        valid_f, ready_f, flush;
  logic [31:0] read_data_d, PC_d, PCPlus4_d;
  logic        valid_d, ready_d;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  fetch_decode_skid_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_data_f (read_data_f),
    .PC_f        (PC_f),
    .PCPlus4_f   (PCPlus4_f),
    .valid_f     (valid_f),
    .ready_f     (ready_f),
    .flush       (flush),
    .read_data_d (read_data_d),
    .PC_d        (PC_d),
    .PCPlus4_d   (PCPlus4_d),
    .valid_d     (valid_d),
    .ready_d     (ready_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    valid_f     = v;
    PC_f        = pc;
    PCPlus4_f   = pc + 32'd4;
    read_data_f = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    $display("cycle %0d: valid_f=%0b ready_f=%0b flush=%0b ready_d=%0b | valid_d=%0b PC_d=%h instr_d=%h",
             cycle, valid_f, ready_f, flush, ready_d, valid_d, PC_d, read_data_d);
  endtask

  task automatic check_d(input string tag, input logic v, input logic rf,
                         input logic [31:0] pc, input logic [31:0] instr);
    check_eq({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, v});
    check_eq({tag, ".ready_f"}, {31'd0, ready_f}, {31'd0, rf});
    check_eq({tag, ".PC_d"}, PC_d, pc);
    check_eq({tag, ".PCPlus4_d"}, PCPlus4_d, pc + 32'd4);
    check_eq({tag, ".instr_d"}, read_data_d, instr);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    ready_d = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    // Reset state
    @(posedge clk);
    #2;
    check_eq("rst.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("rst.ready_f", {31'd0, ready_f}, 32'd1);
    check_eq("rst.instr_d", read_data_d, 32'h0000_0013);
    check_eq("rst.PC_d", PC_d, 32'h0);
    check_eq("rst.PCPlus4_d", PCPlus4_d, 32'h0);
    #1 rst_n = 1'b1;

    // Streaming at full rate
    drive(1'b1, 32'h0, 32'h0050_0093); tick(); check_d("s0", 1'b1, 1'b1, 32'h0, 32'h0050_0093);
    drive(1'b1, 32'h4, 32'h00A0_0113); tick(); check_d("s1", 1'b1, 1'b1, 32'h4, 32'h00A0_0113);
    drive(1'b1, 32'h8, 32'h0020_81B3); tick(); check_d("s2", 1'b1, 1'b1, 32'h8, 32'h0020_81B3);

    // Idle bubble: valid_d drops, data held
    drive(1'b0, 32'hDEAD_0000, 32'hDEAD_BEEF); tick();
    check_eq("idle0.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("idle0.instr_d", read_data_d, 32'h0020_81B3);
    tick();
    check_eq("idle1.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("idle1.PC_d", PC_d, 32'h8);

    // Back-pressure fills the skid, then drains in order
    ready_d = 1'b0;
    drive(1'b1, 32'h10, 32'h1111_0010); tick(); check_d("bp0", 1'b1, 1'b1, 32'h10, 32'h1111_0010);
    drive(1'b1, 32'h14, 32'h1111_0014); tick(); check_d("bp1", 1'b1, 1'b0, 32'h10, 32'h1111_0010);
    drive(1'b1, 32'h18, 32'h1111_0018); tick(); check_d("bp2", 1'b1, 1'b0, 32'h10, 32'h1111_0010);
    ready_d = 1'b1;
    tick(); check_d("dr0", 1'b1, 1'b1, 32'h14, 32'h1111_0014);
    tick(); check_d("dr1", 1'b1, 1'b1, 32'h18, 32'h1111_0018);
    drive(1'b0, 32'h0, 32'h0); tick();
    check_eq("dr2.valid_d", {31'd0, valid_d}, 32'd0);

    // Flush while FULL drops held and incoming beats
    ready_d = 1'b0;
    drive(1'b1, 32'h40, 32'h2222_0040); tick();
    drive(1'b1, 32'h44, 32'h2222_0044); tick(); check_d("fl0", 1'b1, 1'b0, 32'h40, 32'h2222_0040);
    flush = 1'b1;
    drive(1'b1, 32'h20, 32'h2222_0020); tick();
    check_eq("fl1.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("fl1.ready_f", {31'd0, ready_f}, 32'd1);
    check_eq("fl1.PC_d", PC_d, 32'h40);
`ifdef FETCH_REG_FLUSH_NOP_EN
    check_eq("fl1.instr_d", read_data_d, 32'h0000_0013);
`else
    check_eq("fl1.instr_d", read_data_d, 32'h2222_0040);
`endif
    flush   = 1'b0;
    ready_d = 1'b1;
    drive(1'b0, 32'h0, 32'h0); tick();
    check_eq("fl2.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("fl2.PC_d", PC_d, 32'h40);

    // Flush beats a simultaneous ready_d in ONE; the new beat is dropped
    drive(1'b1, 32'h50, 32'h3333_0050); tick(); check_d("fr0", 1'b1, 1'b1, 32'h50, 32'h3333_0050);
    flush = 1'b1;
    drive(1'b1, 32'h54, 32'h3333_0054); tick();
    check_eq("fr1.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("fr1.ready_f", {31'd0, ready_f}, 32'd1);
    check_eq("fr1.PC_d", PC_d, 32'h50);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0); tick();
    check_eq("fr2.valid_d", {31'd0, valid_d}, 32'd0);

    // Asynchronous reset between edges while FULL
    ready_d = 1'b0;
    drive(1'b1, 32'h60, 32'h4444_0060); tick();
    drive(1'b1, 32'h64, 32'h4444_0064); tick(); check_d("ar0", 1'b1, 1'b0, 32'h60, 32'h4444_0060);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar1.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("ar1.ready_f", {31'd0, ready_f}, 32'd1);
    check_eq("ar1.instr_d", read_data_d, 32'h0000_0013);
    check_eq("ar1.PC_d", PC_d, 32'h0);
    check_eq("ar1.PCPlus4_d", PCPlus4_d, 32'h0);
    #2 rst_n = 1'b1;
    ready_d = 1'b1;
    drive(1'b0, 32'h0, 32'h0); tick();
    check_eq("ar2.valid_d", {31'd0, valid_d}, 32'd0);
    check_eq("ar2.instr_d", read_data_d, 32'h0000_0013);
    drive(1'b1, 32'h70, 32'h5555_0070); tick(); check_d("ar3", 1'b1, 1'b1, 32'h70, 32'h5555_0070);
    drive(1'b0, 32'h0, 32'h0); tick();
    check_eq("ar4.valid_d", {31'd0, valid_d}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
